zle_stream: RTL

- Parametrised zero run-length encoder with an input queue and an output queue built in.
- Successor to the fixed 2-bit, EOS-less encoder-plus-Q2 top level.
- Adds a generic data width, configurable queue depths, a maximum-run flush, and full end-of-stream (EOS) handling: a pending run is flushed, then the EOS token is forwarded.
- Sits between producer and consumer streams that use the codebase's data/eos/valid/backpressure convention.

---
 rtl/zle_pkg.sv | 21 ++
 rtl/zle_fifo.sv | 75 +++++++
 rtl/zle_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/zle_pkg.sv
// zle_pkg
// Shared definitions for the zero run-length encoder slice:
//   zle_state_t      encoder FSM states (S_ZERO idle/literal, S_RUN counting zeros)
//   TOK_RUN/TOK_LIT  value of the flag bit (MSB) of an output token
//   tok_width()      output token width for a given data width
package zle_pkg;

  typedef enum logic {
    S_ZERO = 1'b0,
    S_RUN  = 1'b1
  } zle_state_t;

  localparam logic TOK_RUN = 1'b1;
  localparam logic TOK_LIT = 1'b0;

  // Tokens carry one flag bit above the data/run-length field.
  function automatic int tok_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/zle_fifo.sv
// zle_fifo
// Registered FIFO (no fall-through) carrying a data word plus an EOS flag.
// A word pushed in one cycle is visible at the output on the next cycle.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   i_d, i_e, i_v       write side: data, EOS flag, valid
//   i_b                 write-side backpressure, high when full
//   o_d, o_e, o_v       read side: head data, head EOS flag, not-empty
//   o_b                 read-side backpressure, high = do not pop
module zle_fifo #(
  parameter int W_DATA = 2,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [W_DATA-1:0] i_d,
  input  logic              i_e,
  input  logic              i_v,
  output logic              i_b,
  output logic [W_DATA-1:0] o_d,
  output logic              o_e,
  output logic              o_v,
  input  logic              o_b
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W_DATA-1:0] mem_d [DEPTH];
  logic              mem_e [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              full;

  assign full  = (count == CW'(DEPTH));
  assign o_v   = (count != '0);
  assign i_b   = full;
  assign o_d   = mem_d[rd_ptr];
  assign o_e   = mem_e[rd_ptr];
  // Fullness is judged on the registered count, so a pop in the same
  // cycle never makes room for a push into a full FIFO.
  assign push  = i_v && !full;
  assign pop   = o_v && !o_b;

  // Storage is cleared on reset so the read side shows zeros while empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_d[k] <= '0;
        mem_e[k] <= 1'b0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= i_d;
        mem_e[wr_ptr] <= i_e;
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/zle_stream.sv
// zle_stream
// Zero run-length encoder between an input FIFO and an output FIFO.
// Nonzero data become literal tokens {0,value}; runs of zeros become run
// tokens {1,length-1}; EOS is forwarded as o_e=1 with o_d=0 after any
// pending run is flushed. Runs are flushed early when they reach 2^W.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   i_d, i_e, i_v, i_b  producer side: data, EOS, valid, backpressure(out)
//   o_d, o_e, o_v, o_b  consumer side: token, EOS, valid, backpressure(in)
//   stat_lits/stat_runs saturating token counters, present only when the
//                       ZLE_STATS_EN macro is defined; cleared by EOS push
module zle_stream
  import zle_pkg::*;
#(
  parameter int W         = 2,
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 2,
  parameter int STAT_W    = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  input  logic         i_e,
  input  logic         i_v,
  output logic         i_b,
  output logic [W:0]   o_d,
  output logic         o_e,
  output logic         o_v,
  input  logic         o_b
`ifdef ZLE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_lits,
  output logic [STAT_W-1:0] stat_runs
`endif
);

  localparam int TW = tok_width(W);
  // Last count value before a run would reach 2^W zeros.
  localparam logic [W-1:0] CNT_LAST = ~W'(1);

  if (IN_DEPTH < 2 || OUT_DEPTH < 2 || STAT_W < 1) begin : g_bad_params
    $error("zle_stream: IN_DEPTH/OUT_DEPTH must be >= 2 and STAT_W >= 1");
  end

  zle_state_t    state;
  zle_state_t    nxt_state;
  logic [W-1:0]  cnt_m1;
  logic [W-1:0]  nxt_cnt;

  logic [W-1:0]  h_d;
  logic          h_e;
  logic          h_v;
  logic          in_pop;
  logic [TW-1:0] push_d;
  logic          push_e;
  logic          push_v;
  logic          out_full;
  logic          fire;

  zle_fifo #(.W_DATA(W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .i_d   (i_d),
    .i_e   (i_e),
    .i_v   (i_v),
    .i_b   (i_b),
    .o_d   (h_d),
    .o_e   (h_e),
    .o_v   (h_v),
    .o_b   (!in_pop)
  );

  zle_fifo #(.W_DATA(TW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .i_d   (push_d),
    .i_e   (push_e),
    .i_v   (push_v),
    .i_b   (out_full),
    .o_d   (o_d),
    .o_e   (o_e),
    .o_v   (o_v),
    .o_b   (o_b)
  );

  // The encoder only advances when a head token exists and the output
  // FIFO can take a token, so every push here is guaranteed to land.
  assign fire = h_v && !out_full;

  always_comb begin
    in_pop    = 1'b0;
    push_v    = 1'b0;
    push_e    = 1'b0;
    push_d    = '0;
    nxt_state = state;
    nxt_cnt   = cnt_m1;
    if (fire) begin
      case (state)
        S_ZERO: begin
          in_pop = 1'b1;
          if (h_e) begin
            push_v = 1'b1;
            push_e = 1'b1;
          end else if (h_d == '0) begin
            nxt_state = S_RUN;
            nxt_cnt   = '0;
          end else begin
            push_v = 1'b1;
            push_d = {TOK_LIT, h_d};
          end
        end
        S_RUN: begin
          if (!h_e && h_d == '0) begin
            in_pop = 1'b1;
            if (cnt_m1 == CNT_LAST) begin
              push_v    = 1'b1;
              push_d    = {TOK_RUN, {W{1'b1}}};
              nxt_state = S_ZERO;
            end else begin
              nxt_cnt = cnt_m1 + 1'b1;
            end
          end else begin
            // Terminator stays at the head; it is encoded on the next fire.
            push_v    = 1'b1;
            push_d    = {TOK_RUN, cnt_m1};
            nxt_state = S_ZERO;
          end
        end
        default: nxt_state = S_ZERO;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_ZERO;
      cnt_m1 <= '0;
    end else begin
      state  <= nxt_state;
      cnt_m1 <= nxt_cnt;
    end
  end

`ifdef ZLE_STATS_EN
  // Token counters restart with each stream: an EOS push clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_lits <= '0;
      stat_runs <= '0;
    end else if (push_v) begin
      if (push_e) begin
        stat_lits <= '0;
        stat_runs <= '0;
      end else if (push_d[W] == TOK_RUN) begin
        if (stat_runs != '1) stat_runs <= stat_runs + 1'b1;
      end else begin
        if (stat_lits != '1) stat_lits <= stat_lits + 1'b1;
      end
    end
  end
`endif

endmodule
